core_dispatch_scoreboard: RTL and testbench

//  N-wide in-order dispatch gate with a registered register scoreboard; generalises 2-slot mask-based hazard check.

---
 rtl/core_dispatch_scoreboard.sv | 114 +++++++++++
 tb/tb_core_dispatch_scoreboard.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dispatch_scoreboard.sv
// rtl/core_dispatch_scoreboard.sv - N-wide in-order dispatch gate with registered register scoreboard
// Issues the longest hazard-free prefix of slots and tracks in-flight destinations until owner writeback.
module core_dispatch_scoreboard #(
  parameter int                 ISSUE_WIDTH = 2,
  parameter int                 NUM_REGS    = 16,
  parameter int                 NUM_EUS     = 4,
  parameter logic [NUM_EUS-1:0] SHARED_EUS  = 'b1100,
  parameter int                 STALL_W     = 16,
  localparam int                RW          = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ISSUE_WIDTH-1:0]         slot_valid,
  input  logic [ISSUE_WIDTH-1:0]         slot_execute,
  input  logic [ISSUE_WIDTH-1:0]         slot_uses_ra,
  input  logic [ISSUE_WIDTH-1:0]         slot_uses_rb,
  input  logic [ISSUE_WIDTH-1:0]         slot_wb,
  input  logic [ISSUE_WIDTH*RW-1:0]      slot_ra,
  input  logic [ISSUE_WIDTH*RW-1:0]      slot_rb,
  input  logic [ISSUE_WIDTH*RW-1:0]      slot_rd,
  input  logic [ISSUE_WIDTH*NUM_EUS-1:0] slot_eu,
  input  logic [NUM_EUS-1:0]             eu_ready,
  input  logic [NUM_EUS-1:0]             wb_valid,
  input  logic [NUM_EUS*RW-1:0]          wb_rd,
  input  logic                           branch_stall,
  output logic [ISSUE_WIDTH-1:0]         dispatch,
  output logic [NUM_REGS-1:0]            busy_mask,
  output logic [STALL_W-1:0]             stall_count
);

  localparam int EW = (NUM_EUS > 1) ? $clog2(NUM_EUS) : 1;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [EW-1:0]       owner_q [NUM_REGS];
  logic [EW-1:0]       owner_d [NUM_REGS];
  logic [STALL_W-1:0]  stall_q;
  logic [ISSUE_WIDTH-1:0] disp;

  logic               chain, hazard, live_j;
  logic [NUM_EUS-1:0] taken, eu_i;
  logic [RW-1:0]      ra_i, rb_i, rd_i, rd_j;

  // chain carries the prefix: once a slot is blocked no younger slot may issue
  always_comb begin
    disp   = '0;
    chain  = rst_n && !branch_stall;
    taken  = '0;
    hazard = 1'b0;
    live_j = 1'b0;
    eu_i   = '0;
    ra_i   = '0;
    rb_i   = '0;
    rd_i   = '0;
    rd_j   = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      ra_i   = slot_ra[i*RW +: RW];
      rb_i   = slot_rb[i*RW +: RW];
      rd_i   = slot_rd[i*RW +: RW];
      eu_i   = slot_eu[i*NUM_EUS +: NUM_EUS];
      hazard = !$onehot(eu_i) || ((eu_i & eu_ready) == '0) ||
               ((eu_i & SHARED_EUS & taken) != '0);
      if (slot_uses_ra[i] && busy_q[ra_i]) hazard = 1'b1;
      if (slot_uses_rb[i] && busy_q[rb_i]) hazard = 1'b1;
      if (slot_wb[i] && busy_q[rd_i])      hazard = 1'b1;
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
        rd_j   = slot_rd[j*RW +: RW];
        live_j = (j < i) && slot_valid[j] && slot_execute[j] && slot_wb[j];
        if (live_j && slot_uses_ra[i] && (rd_j == ra_i)) hazard = 1'b1;
        if (live_j && slot_uses_rb[i] && (rd_j == rb_i)) hazard = 1'b1;
        if (live_j && slot_wb[i] && (rd_j == rd_i))      hazard = 1'b1;
      end
      if (!slot_valid[i] || !slot_execute[i]) hazard = 1'b0;
      chain   = chain && !hazard;
      disp[i] = chain;
      if (chain && slot_valid[i] && slot_execute[i]) taken = taken | eu_i;
    end
  end

  // clears are applied before sets so a same-cycle re-dispatch keeps the register busy
  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    for (int e = 0; e < NUM_EUS; e++) begin
      if (wb_valid[e] && (owner_q[wb_rd[e*RW +: RW]] == EW'(e)))
        busy_d[wb_rd[e*RW +: RW]] = 1'b0;
    end
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (disp[i] && slot_valid[i] && slot_execute[i] && slot_wb[i]) begin
        busy_d[slot_rd[i*RW +: RW]] = 1'b1;
        for (int e = 0; e < NUM_EUS; e++) begin
          if (slot_eu[i*NUM_EUS + e]) owner_d[slot_rd[i*RW +: RW]] = EW'(e);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      stall_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) owner_q[r] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int r = 0; r < NUM_REGS; r++) owner_q[r] <= owner_d[r];
      if (slot_valid[0] && !disp[0] && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign dispatch    = disp;
  assign busy_mask   = busy_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_core_dispatch_scoreboard.sv
// tb/tb_core_dispatch_scoreboard.sv - randomized and directed checks of core_dispatch_scoreboard
// A set-based reference model predicts the issued prefix length, busy registers and stall count.
module tb_core_dispatch_scoreboard;

  localparam int IW = 4;
  localparam int NR = 16;
  localparam int NE = 4;
  localparam int RW = 4;
  localparam int SW = 16;
  localparam logic [NE-1:0] SHARED = 4'b1100;

  logic clk = 1'b0;
  logic rst_n;
  logic [IW-1:0]    slot_valid, slot_execute, slot_uses_ra, slot_uses_rb, slot_wb;
  logic [IW*RW-1:0] slot_ra, slot_rb, slot_rd;
  logic [IW*NE-1:0] slot_eu;
  logic [NE-1:0]    eu_ready, wb_valid;
  logic [NE*RW-1:0] wb_rd;
  logic             branch_stall;
  logic [IW-1:0]    dispatch;
  logic [NR-1:0]    busy_mask;
  logic [SW-1:0]    stall_count;

  always #5 clk = ~clk;

  core_dispatch_scoreboard #(
    .ISSUE_WIDTH(IW), .NUM_REGS(NR), .NUM_EUS(NE), .SHARED_EUS(SHARED), .STALL_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .slot_valid(slot_valid), .slot_execute(slot_execute),
    .slot_uses_ra(slot_uses_ra), .slot_uses_rb(slot_uses_rb), .slot_wb(slot_wb),
    .slot_ra(slot_ra), .slot_rb(slot_rb), .slot_rd(slot_rd), .slot_eu(slot_eu),
    .eu_ready(eu_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .branch_stall(branch_stall),
    .dispatch(dispatch), .busy_mask(busy_mask), .stall_count(stall_count)
  );

  bit   v[IW], ex[IW], ura[IW], urb[IW], wb[IW];
  int   ra[IW], rb[IW], rd[IW];
  logic [NE-1:0] eu[IW];
  logic [NE-1:0] rdy, wbv;
  int   wbr[NE];
  bit   bst;

  bit [NR-1:0] m_busy;
  int          m_owner[NR];
  int          m_stall;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < IW; i++) begin
      v[i] = 0; ex[i] = 0; ura[i] = 0; urb[i] = 0; wb[i] = 0;
      ra[i] = 0; rb[i] = 0; rd[i] = 0; eu[i] = 4'b0001;
    end
    for (int e = 0; e < NE; e++) wbr[e] = 0;
    rdy = '1; wbv = '0; bst = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < IW; i++) begin
      slot_valid[i] = v[i]; slot_execute[i] = ex[i];
      slot_uses_ra[i] = ura[i]; slot_uses_rb[i] = urb[i]; slot_wb[i] = wb[i];
      slot_ra[i*RW +: RW] = RW'(ra[i]);
      slot_rb[i*RW +: RW] = RW'(rb[i]);
      slot_rd[i*RW +: RW] = RW'(rd[i]);
      slot_eu[i*NE +: NE] = eu[i];
    end
    for (int e = 0; e < NE; e++) wb_rd[e*RW +: RW] = RW'(wbr[e]);
    eu_ready = rdy; wb_valid = wbv; branch_stall = bst;
  endtask

  // number of leading slots that may issue, from the sets of busy and same-cycle-claimed resources
  function automatic int model_prefix();
    bit [NR-1:0] pend;
    logic [NE-1:0] used;
    bit bad;
    pend = '0; used = '0;
    if (!rst_n || bst) return 0;
    for (int i = 0; i < IW; i++) begin
      if (v[i] && ex[i]) begin
        bad = 0;
        if (ura[i] && (m_busy[ra[i]] || pend[ra[i]])) bad = 1;
        if (urb[i] && (m_busy[rb[i]] || pend[rb[i]])) bad = 1;
        if (wb[i] && (m_busy[rd[i]] || pend[rd[i]])) bad = 1;
        if ($countones(eu[i]) != 1 || (eu[i] & rdy) == '0) bad = 1;
        if ((eu[i] & SHARED & used) != '0) bad = 1;
        if (bad) return i;
        if (wb[i]) pend[rd[i]] = 1;
        used = used | eu[i];
      end
    end
    return IW;
  endfunction

  task automatic model_update(input int n);
    for (int e = 0; e < NE; e++)
      if (wbv[e] && m_owner[wbr[e]] == e) m_busy[wbr[e]] = 0;
    for (int i = 0; i < n; i++) begin
      if (v[i] && ex[i] && wb[i]) begin
        m_busy[rd[i]] = 1;
        for (int e = 0; e < NE; e++) if (eu[i][e]) m_owner[rd[i]] = e;
      end
    end
    if (v[0] && n == 0 && m_stall < 65535) m_stall++;
  endtask

  task automatic cycle(input int lit);
    int n;
    logic [IW-1:0] exp_d;
    drive();
    #2;
    n = model_prefix();
    exp_d = '0;
    for (int k = 0; k < n; k++) exp_d[k] = 1'b1;
    check("dispatch", dispatch, exp_d);
    if (lit >= 0) check("dispatch_literal", dispatch, lit);
    model_update(n);
    @(posedge clk); #1;
    check("busy_mask", busy_mask, m_busy);
    check("stall_count", stall_count, m_stall);
  endtask

  task automatic do_reset();
    clear_slots(); drive();
    @(posedge clk); #3;
    rst_n = 0; #1;
    check("reset_dispatch", dispatch, 0);
    check("reset_busy", busy_mask, 0);
    check("reset_stall", stall_count, 0);
    m_busy = '0; m_stall = 0;
    for (int r = 0; r < NR; r++) m_owner[r] = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic random_cycles(input int count);
    int q[$];
    for (int c = 0; c < count; c++) begin
      for (int i = 0; i < IW; i++) begin
        v[i] = ($urandom % 4) != 0; ex[i] = ($urandom % 5) != 0;
        ura[i] = $urandom % 2; urb[i] = $urandom % 2; wb[i] = $urandom % 2;
        ra[i] = $urandom % 8; rb[i] = $urandom % 8; rd[i] = $urandom % 6;
        eu[i] = ($urandom % 20 == 0) ? NE'($urandom) : NE'(1 << ($urandom % NE));
      end
      for (int e = 0; e < NE; e++) begin
        rdy[e] = ($urandom % 4) != 0;
        wbv[e] = ($urandom % 3) == 0;
        q.delete();
        for (int r = 0; r < NR; r++) if (m_busy[r] && m_owner[r] == e) q.push_back(r);
        if (q.size() > 0 && ($urandom % 4) != 0) wbr[e] = q[$urandom % q.size()];
        else wbr[e] = $urandom % NR;
      end
      bst = ($urandom % 10) == 0;
      cycle(-1);
    end
  endtask

  initial begin
    rst_n = 0;
    clear_slots(); drive();
    #12;
    do_reset();

    // producer/consumer in one group, then consumer waits for writeback
    clear_slots();
    v[0] = 1; ex[0] = 1; wb[0] = 1; rd[0] = 3; eu[0] = 4'b0001;
    v[1] = 1; ex[1] = 1; ura[1] = 1; ra[1] = 3; eu[1] = 4'b0010;
    cycle(4'b0001);
    check("raw_busy_set", busy_mask, 16'h0008);
    v[0] = 0;
    cycle(4'b0001);
    wbv[0] = 1; wbr[0] = 3;
    cycle(4'b0001);
    check("raw_busy_clear", busy_mask, 16'h0000);
    wbv = '0;
    cycle(4'b1111);
    check("raw_stall_none", stall_count, 0);

    // shared ldst unit, squash, and EU not ready
    clear_slots();
    v[0] = 1; ex[0] = 1; eu[0] = 4'b1000;
    v[1] = 1; ex[1] = 1; eu[1] = 4'b1000;
    cycle(4'b0001);
    ex[0] = 0;
    cycle(4'b1111);
    ex[0] = 1; rdy = 4'b0111;
    cycle(4'b0000);

    // same-cycle set and stale-owner writeback
    clear_slots();
    v[0] = 1; ex[0] = 1; wb[0] = 1; rd[0] = 5; eu[0] = 4'b0010;
    cycle(4'b1111);
    check("owner_b_busy", busy_mask, 16'h0020);
    v[0] = 0; wbv[1] = 1; wbr[1] = 5;
    cycle(4'b1111);
    check("owner_b_clear", busy_mask, 16'h0000);
    v[0] = 1; eu[0] = 4'b0001;
    cycle(4'b1111);
    check("set_wins", busy_mask, 16'h0020);
    v[0] = 0;
    cycle(4'b1111);
    check("stale_wb_ignored", busy_mask, 16'h0020);
    wbv = '0; wbv[0] = 1; wbr[0] = 5;
    cycle(4'b1111);
    check("owner_a_clear", busy_mask, 16'h0000);

    // prefix rule across four slots
    clear_slots();
    v[0] = 1; ex[0] = 1; wb[0] = 1; rd[0] = 7; eu[0] = 4'b0001;
    cycle(4'b1111);
    check("prefix_busy", busy_mask, 16'h0080);
    clear_slots();
    v[0] = 1; ex[0] = 1; eu[0] = 4'b0001;
    v[1] = 1; ex[1] = 1; ura[1] = 1; ra[1] = 7; eu[1] = 4'b0010;
    v[2] = 1; ex[2] = 1; eu[2] = 4'b0100;
    v[3] = 1; ex[3] = 1; eu[3] = 4'b1000;
    cycle(4'b0001);
    wbv[0] = 1; wbr[0] = 7;
    cycle(4'b0001);
    wbv = '0;
    cycle(4'b1111);

    // malformed EU selection never issues
    clear_slots();
    v[0] = 1; ex[0] = 1; eu[0] = 4'b0011;
    cycle(4'b0000);
    eu[0] = 4'b0000;
    cycle(4'b0000);

    // branch freeze counts stalls
    do_reset();
    clear_slots();
    v[0] = 1; ex[0] = 1; eu[0] = 4'b0001; bst = 1;
    cycle(4'b0000); cycle(4'b0000); cycle(4'b0000);
    check("branch_stall_count", stall_count, 3);
    bst = 0;
    cycle(4'b1111);
    check("branch_stall_hold", stall_count, 3);

    random_cycles(700);
    do_reset();
    random_cycles(700);

    // saturation of the stall counter
    do_reset();
    clear_slots();
    v[0] = 1; ex[0] = 1; eu[0] = 4'b0001; bst = 1;
    drive();
    repeat (65534) @(posedge clk);
    #1;
    check("stall_near_sat", stall_count, 16'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    check("stall_saturated", stall_count, 16'hFFFF);
    check("stall_sat_dispatch", dispatch, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
